// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package seq_det_pkg;

    // Out-of-reset configuration: the legacy 1101 overlapping detector.
    localparam logic [3:0]  DEFAULT_PAT = 4'b1101;
    localparam int unsigned DEFAULT_LEN = 4;
    localparam logic        DEFAULT_OVL = 1'b1;

    // Pattern lengths beyond the history depth collapse to the full depth.
    function automatic int unsigned clamp_len(input int unsigned len_in,
                                              input int unsigned pat_w);
        return (len_in > pat_w) ? pat_w : len_in;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: q reflects inc/clr one cycle after they are sampled.
// Backpressure: none; inc is accepted every cycle, holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with saturating match count.
// Latency: out pulses the cycle after the edge that samples the final bit.
// Backpressure: none; one bit per cycle when in_valid, load drops that bit.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             ovl_in,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    // Configuration registers.
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;

    // Datapath registers.
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             out_q, out_d;

    // Intermediate compare terms.
    logic [PAT_W-1:0] h_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_inc;
    logic             accept;
    logic             pat_eq;
    logic             match;

    // Match evaluation on the history as it will look after this bit.
    always_comb begin
        accept   = in_valid && !load;
        h_next   = (hist_q << 1) | PAT_W'(in);
        // fill never exceeds len, so the increment cannot overflow LEN_W.
        fill_inc = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : len_q;
        mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        // Bits above len are forced to agree so only the live window counts.
        pat_eq   = &((h_next ~^ pat_q) | ~mask);
        match    = accept && (len_q != '0) && (fill_inc == len_q) && pat_eq;
    end

    // Next-state for configuration, history, fill level and match pulse.
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        if (load) begin
            pat_d  = pat_in;
            len_d  = LEN_W'(clamp_len(32'(len_in), PAT_W));
            ovl_d  = ovl_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = h_next;
            // Non-overlapping mode restarts the window after each hit.
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
            out_d  = match;
        end
    end

    // State registers; reset restores the legacy detector configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PAT_W'(DEFAULT_PAT);
            len_q  <= LEN_W'(DEFAULT_LEN);
            ovl_q  <= DEFAULT_OVL;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .inc(match),
        .clr(clr_cnt),
        .q  (match_cnt)
    );

    assign out = out_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param with a pulse scoreboard.
// Latency: expects each pulse on the cycle after its final bit's edge.
// Backpressure: none; stimulus drives one cycle per call.
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk;
    logic             rst;
    logic             din;
    logic             in_valid;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] len_in;
    logic             ovl_in;
    logic             clr_cnt;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    typedef struct {
        int edge_no;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    seq_detector_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (din),
        .in_valid (in_valid),
        .load     (load),
        .pat_in   (pat_in),
        .len_in   (len_in),
        .ovl_in   (ovl_in),
        .clr_cnt  (clr_cnt),
        .out      (out),
        .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a pulse must appear exactly on its expected cycle with the expected count.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (out !== 1'b1 || int'(match_cnt) != e.cnt) begin
                    errors++;
                    $display("FAIL pulse@%0d: out=%b cnt=%0d, expected out=1 cnt=%0d",
                             cyc, out, match_cnt, e.cnt);
                end
            end else if (out !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse@%0d: out=%b, expected out=0", cyc, out);
            end
        end
    end

    task automatic check_now(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One cycle with a bit presented; m marks it as completing a match with count c.
    task automatic bit_in(input logic b, input logic clr, input bit m, input int c);
        din      = b;
        in_valid = 1'b1;
        clr_cnt  = clr;
        load     = 1'b0;
        if (m) exp_q.push_back('{cyc + 1, c});
        @(negedge clk);
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        load     = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_cnt();
        in_valid = 1'b0;
        clr_cnt  = 1'b1;
        @(negedge clk);
        clr_cnt  = 1'b0;
    endtask

    // Load with a valid bit also presented; that bit must be dropped.
    task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                            input logic o);
        pat_in   = p;
        len_in   = l;
        ovl_in   = o;
        load     = 1'b1;
        in_valid = 1'b1;
        din      = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; in_valid = 1'b0; load = 1'b0;
        pat_in = '0; len_in = '0; ovl_in = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_now("reset_out", int'(out), 0);
        check_now("reset_cnt", int'(match_cnt), 0);
        rst = 1'b0;

        // Defaults: 1101101 overlapping, hits on bits 4 and 7.
        bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 1, 1);
        bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 1, 2);
        gap();
        check_now("default_cnt", int'(match_cnt), 2);
        clear_cnt();
        check_now("clr_cnt", int'(match_cnt), 0);

        // 101 non-overlapping on 10101: one hit.
        load_cfg(8'b101, 4'd3, 1'b0);
        bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 1, 1);
        bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
        clear_cnt();
        // 101 overlapping on 10101: hits on bits 3 and 5.
        load_cfg(8'b101, 4'd3, 1'b1);
        bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 1, 1);
        bit_in(0, 0, 0, 0); bit_in(1, 0, 1, 2);
        clear_cnt();

        // 1101 with idle gaps between bits.
        load_cfg(8'b1101, 4'd4, 1'b1);
        bit_in(1, 0, 0, 0); gap(); bit_in(1, 0, 0, 0); gap(); gap();
        bit_in(0, 0, 0, 0); gap(); bit_in(1, 0, 1, 1); gap(); gap();
        clear_cnt();

        // Single-bit pattern: counter saturates at 3, clear beats a simultaneous hit.
        load_cfg(8'b1, 4'd1, 1'b1);
        bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 2); bit_in(1, 0, 1, 3);
        bit_in(1, 0, 1, 3); bit_in(1, 0, 1, 3);
        bit_in(1, 1, 1, 0);
        bit_in(1, 0, 1, 1);

        // Load leaves the count alone; reset mid-pattern discards it and restores config.
        load_cfg(8'b0110, 4'd4, 1'b0);
        check_now("load_keeps_cnt", int'(match_cnt), 1);
        bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_now("midrst_out", int'(out), 0);
        check_now("midrst_cnt", int'(match_cnt), 0);
        rst = 1'b0;
        bit_in(1, 0, 0, 0);
        bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 1, 1);

        // Load during a partial 110 must force len fresh bits.
        bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
        load_cfg(8'b1101, 4'd4, 1'b1);
        bit_in(1, 0, 0, 0);
        bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 1, 2);
        clear_cnt();

        // Length 0 disables detection even with an all-zero pattern.
        load_cfg(8'b0, 4'd0, 1'b1);
        bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
        gap();
        check_now("len0_cnt", int'(match_cnt), 0);

        // Oversized length clamps to the full 8-bit window.
        load_cfg(8'b1011_0011, 4'(PAT_W + 3), 1'b1);
        bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0);
        bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 1, 1);
        bit_in(0, 0, 0, 0);
        gap(); gap();

        check_now("pending_pulses", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach its end, expected completion");
        $fatal(1);
    end

endmodule
